// File: rtl/d_input_debouncer.sv
// d_input_debouncer: resynchronises a raw input and accepts a new level only after it holds for STABLE_CYCLES cycles
module d_input_debouncer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din_raw,
    input  logic enable,
    output logic d_out,
    output logic rise,
    output logic fall,
    output logic busy
);
    localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(STABLE_CYCLES - 1);
    typedef enum logic {IDLE, COUNT} state_t;
    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic d_out_q, d_out_d, rise_q, rise_d, fall_q, fall_d, busy_q;
    logic s, qual, take;
    if (SYNC_STAGES < 2 || STABLE_CYCLES < 1) begin : g_bad_params
        $fatal(1, "d_input_debouncer: SYNC_STAGES must be >= 2 and STABLE_CYCLES >= 1");
    end
    assign s    = sync_q[SYNC_STAGES-1];
    assign qual = enable && (s != d_out_q);
    // A single-cycle qualification resolves straight from IDLE
    assign take = qual && (state_q == COUNT || STABLE_CYCLES == 1) && (cnt_q == TERM);
    always_comb begin
        state_d = (qual && !take) ? COUNT : IDLE;
        cnt_d   = (qual && !take) ? ((state_q == COUNT) ? cnt_q + CNT_W'(1) : CNT_W'(1)) : '0;
        d_out_d = take ? s : d_out_q;
        rise_d  = take && s;
        fall_d  = take && !s;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            d_out_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], din_raw};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_out_q <= d_out_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= (cnt_d != '0);
        end
    end
    assign d_out = d_out_q;
    assign rise  = rise_q;
    assign fall  = fall_q;
    assign busy  = busy_q;
endmodule

// File: tb/tb_d_input_debouncer.sv
// tb_d_input_debouncer: scoreboard bench comparing two debouncer instances against a run-length reference model
module tb_d_input_debouncer;
    localparam int SYNC = 2;
    logic clk = 1'b0, reset = 1'b1, din_raw = 1'b0, enable = 1'b1;
    logic d0, r0, f0, b0, d1, r1, f1, b1;
    int checks = 0, errors = 0;
    int st[2] = '{4, 1};
    logic hist[$];
    logic md[2], mr[2], mf[2];
    int run[2];
    logic [3:0] sbq0[$], sbq1[$];
    always #5 clk = ~clk;
    d_input_debouncer #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(4)) u_dut0 (
        .clk(clk), .reset(reset), .din_raw(din_raw), .enable(enable),
        .d_out(d0), .rise(r0), .fall(f0), .busy(b0)
    );
    d_input_debouncer #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset), .din_raw(din_raw), .enable(enable),
        .d_out(d1), .rise(r1), .fall(f1), .busy(b1)
    );
    function automatic void model_clear();
        hist = {};
        for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
        for (int i = 0; i < 2; i++) begin
            md[i] = 1'b0; mr[i] = 1'b0; mf[i] = 1'b0; run[i] = 0;
        end
    endfunction
    // The output level flips on the STABLE_CYCLES-th consecutive edge where the
    // input seen SYNC edges ago differs from the output while enabled.
    function automatic void model_edge();
        logic s;
        if (!reset) return;
        s = hist.pop_front();
        hist.push_back(din_raw);
        for (int i = 0; i < 2; i++) begin
            mr[i] = 1'b0; mf[i] = 1'b0;
            run[i] = (enable && s != md[i]) ? run[i] + 1 : 0;
            if (run[i] == st[i]) begin
                md[i] = s; mr[i] = s; mf[i] = !s; run[i] = 0;
            end
        end
    endfunction
    task automatic cyc(input logic dv, input logic ev, input logic rv);
        @(posedge clk);
        model_edge();
        #1;
        din_raw = dv; enable = ev; reset = rv;
        if (!rv) model_clear();
        #1;
        sbq0.push_back({md[0], mr[0], mf[0], run[0] != 0});
        sbq1.push_back({md[1], mr[1], mf[1], run[1] != 0});
    endtask
    task automatic chk(input string nm, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %b want %b at %0t", nm, a, e, $time);
        end
    endtask
    always @(negedge clk) begin
        logic [3:0] e;
        if (sbq0.size() != 0) begin
            e = sbq0.pop_front();
            checks++;
            if ({d0, r0, f0, b0} !== e) begin
                errors++;
                $display("FAIL sb0 {d,rise,fall,busy} got %b want %b at %0t", {d0, r0, f0, b0}, e, $time);
            end
        end
        if (sbq1.size() != 0) begin
            e = sbq1.pop_front();
            checks++;
            if ({d1, r1, f1, b1} !== e) begin
                errors++;
                $display("FAIL sb1 {d,rise,fall,busy} got %b want %b at %0t", {d1, r1, f1, b1}, e, $time);
            end
        end
        checks++;
        if ((r0 && f0) || (r1 && f1)) begin
            errors++;
            $display("FAIL strobe_excl got r0f0=%b%b r1f1=%b%b want not both at %0t", r0, f0, r1, f1, $time);
        end
    end
    initial begin
        #1 reset = 1'b0;
        model_clear();
        #1;
        chk("rst_d0", d0, 1'b0);
        chk("rst_busy0", b0, 1'b0);
        chk("rst_rise0", r0, 1'b0);
        chk("rst_fall1", f1, 1'b0);
        repeat (2) cyc(1'b0, 1'b1, 1'b0);
        repeat (4) cyc(1'b0, 1'b1, 1'b1);
        // clean step
        cyc(1'b1, 1'b1, 1'b1);
        repeat (5) cyc(1'b1, 1'b1, 1'b1);
        chk("step_d_e5", d0, 1'b0);
        chk("step_busy_e5", b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        chk("step_d_e6", d0, 1'b1);
        chk("step_rise_e6", r0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        chk("step_rise_e7", r0, 1'b0);
        repeat (10) cyc(1'b0, 1'b1, 1'b1);
        // glitch rejection
        repeat (3) cyc(1'b1, 1'b1, 1'b1);
        repeat (10) cyc(1'b0, 1'b1, 1'b1);
        chk("glitch_d", d0, 1'b0);
        chk("glitch_busy", b0, 1'b0);
        // bounce then settle
        cyc(1'b1, 1'b1, 1'b1); cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1); cyc(1'b0, 1'b1, 1'b1);
        repeat (8) cyc(1'b1, 1'b1, 1'b1);
        chk("bounce_d", d0, 1'b1);
        repeat (10) cyc(1'b0, 1'b1, 1'b1);
        // enable gating
        repeat (20) cyc(1'b1, 1'b0, 1'b1);
        chk("gate_d", d0, 1'b0);
        chk("gate_busy", b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        repeat (3) cyc(1'b1, 1'b1, 1'b1);
        chk("gate_d_e3", d0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        chk("gate_d_e4", d0, 1'b1);
        repeat (10) cyc(1'b0, 1'b1, 1'b1);
        // reset mid-count
        cyc(1'b1, 1'b1, 1'b1);
        repeat (3) cyc(1'b1, 1'b1, 1'b1);
        chk("midrst_busy_pre", b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0);
        chk("midrst_busy", b0, 1'b0);
        chk("midrst_d1", d1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        repeat (5) cyc(1'b1, 1'b1, 1'b1);
        chk("midrst_d_e5", d0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        chk("midrst_d_e6", d0, 1'b1);
        repeat (4) cyc(1'b1, 1'b1, 1'b1);
        // single-cycle qualification instance
        cyc(1'b0, 1'b1, 1'b1);
        repeat (2) cyc(1'b0, 1'b1, 1'b1);
        chk("sc1_d_e2", d1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        chk("sc1_d_e3", d1, 1'b0);
        chk("sc1_fall_e3", f1, 1'b1);
        chk("sc1_busy_e3", b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        chk("sc1_fall_e4", f1, 1'b0);
        repeat (600) begin
            logic dv, ev, rv;
            dv = ($urandom_range(0, 4) == 0) ? ~din_raw : din_raw;
            ev = ($urandom_range(0, 15) != 0);
            rv = ($urandom_range(0, 99) != 0);
            cyc(dv, ev, rv);
        end
        repeat (3) cyc(din_raw, 1'b1, 1'b1);
        @(negedge clk);
        #1;
        checks++;
        if (sbq0.size() != 0 || sbq1.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d/%0d pending want 0/0", sbq0.size(), sbq1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
